// File: rtl/mand_tile_sequencer_pkg.sv
// Shared definitions for the Mandelbrot tile sequencer: lane geometry,
// request FSM encoding and the shift-add multiply by eleven.
package mand_tile_sequencer_pkg;

    localparam int LANES = 11;
    localparam int CW    = 7;
    localparam int CNT_W = LANES * CW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } mand_state_e;

    // 11*x = 8x + 2x + x, wrapping mod 2^32
    function automatic logic [31:0] times11(input logic [31:0] x);
        return (x << 3) + (x << 1) + x;
    endfunction

endpackage

// File: rtl/mand_lane_unpacker.sv
// Single-entry drain buffer: holds one block's packed lane counters and
// streams them out as LANES pixel writes on a valid/ready interface.
module mand_lane_unpacker
    import mand_tile_sequencer_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_counters,
    input  logic [AW-1:0]    load_addr,
    output logic             full,
    output logic             drain_last,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [AW-1:0]    px_addr,
    output logic [CW-1:0]    px_data
);

    logic [CNT_W-1:0] buf_q;
    logic [AW-1:0]    addr_q;
    logic [3:0]       lane_q;
    logic             full_q;
    logic             accept;

    assign accept     = full_q && px_ready;
    assign drain_last = accept && (lane_q == 4'(LANES - 1));

    assign full     = full_q;
    assign px_valid = full_q;
    assign px_addr  = addr_q;
    assign px_data  = buf_q[CW-1:0];

    // Lane 1 sits in the low bits; each accept shifts the next lane down
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q  <= '0;
            addr_q <= '0;
            lane_q <= '0;
            full_q <= 1'b0;
        end else if (load) begin
            buf_q  <= load_counters;
            addr_q <= load_addr;
            lane_q <= '0;
            full_q <= 1'b1;
        end else if (accept) begin
            buf_q  <= buf_q >> CW;
            addr_q <= addr_q + AW'(1);
            lane_q <= lane_q + 4'd1;
            if (drain_last) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mand_tile_sequencer.sv
// Walks an NROWS x NBLK tile, issuing one core request per 11-pixel block
// and draining each block's counters to the framebuffer stream.
module mand_tile_sequencer
    import mand_tile_sequencer_pkg::*;
#(
    parameter int AW = 20,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      x0,
    input  logic [31:0]      y0,
    input  logic [31:0]      dx,
    input  logic [31:0]      dy,
    input  logic [DW-1:0]    nblk,
    input  logic [DW-1:0]    nrows,
    input  logic [AW-1:0]    base,
    input  logic [AW-1:0]    stride,
    output logic             busy,
    output logic             done,
    output logic [31:0]      core_cx0,
    output logic [31:0]      core_cxstep,
    output logic [31:0]      core_cy,
    output logic             core_rq,
    input  logic             core_ack,
    input  logic [CNT_W-1:0] core_counters,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [AW-1:0]    px_addr,
    output logic [CW-1:0]    px_data
);

    mand_state_e   state_q, state_n;
    logic [31:0]   x0_q, dy_q, dx11_q;
    logic [AW-1:0] stride_q, row_addr_q, blk_addr_q;
    logic [DW-1:0] nblk_q, nrows_q, blk_q, row_q;
    logic          fin_q;
    logic          take_start, zero_start, load, req_now;
    logic          row_end, last_blk;
    logic          buf_full, drain_last;

    assign row_end  = (blk_q == nblk_q - DW'(1));
    assign last_blk = row_end && (row_q == nrows_q - DW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // done blocks a restart in the same cycle busy falls
    always_comb begin
        state_n    = state_q;
        take_start = 1'b0;
        zero_start = 1'b0;
        load       = 1'b0;
        req_now    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !busy && !done) begin
                    if (nblk == '0 || nrows == '0) begin
                        zero_start = 1'b1;
                    end else begin
                        take_start = 1'b1;
                        state_n    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                req_now = 1'b1;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_ack) begin
                    if (!buf_full) begin
                        load = 1'b1;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!buf_full) begin
                    load = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (load) begin
            state_n = last_blk ? ST_IDLE : ST_REQ;
        end
    end

    // Position accumulators step on each capture so the next request is ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0_q        <= '0;
            dy_q        <= '0;
            dx11_q      <= '0;
            stride_q    <= '0;
            nblk_q      <= '0;
            nrows_q     <= '0;
            blk_q       <= '0;
            row_q       <= '0;
            row_addr_q  <= '0;
            blk_addr_q  <= '0;
            core_cx0    <= '0;
            core_cy     <= '0;
            core_cxstep <= '0;
        end else if (take_start) begin
            x0_q        <= x0;
            dy_q        <= dy;
            dx11_q      <= times11(dx);
            stride_q    <= stride;
            nblk_q      <= nblk;
            nrows_q     <= nrows;
            blk_q       <= '0;
            row_q       <= '0;
            row_addr_q  <= base;
            blk_addr_q  <= base;
            core_cx0    <= x0;
            core_cy     <= y0;
            core_cxstep <= dx;
        end else if (load && !last_blk) begin
            if (row_end) begin
                blk_q      <= '0;
                row_q      <= row_q + DW'(1);
                core_cx0   <= x0_q;
                core_cy    <= core_cy + dy_q;
                row_addr_q <= row_addr_q + stride_q;
                blk_addr_q <= row_addr_q + stride_q;
            end else begin
                blk_q      <= blk_q + DW'(1);
                core_cx0   <= core_cx0 + dx11_q;
                blk_addr_q <= blk_addr_q + AW'(LANES);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rq <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            core_rq <= req_now;
            done    <= zero_start || (fin_q && drain_last);
            if (take_start) begin
                busy <= 1'b1;
            end else if (fin_q && drain_last) begin
                busy <= 1'b0;
            end
            if (load && last_blk) begin
                fin_q <= 1'b1;
            end else if (drain_last) begin
                fin_q <= 1'b0;
            end
        end
    end

    mand_lane_unpacker #(
        .AW (AW)
    ) u_unpacker (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .load_counters (core_counters),
        .load_addr     (blk_addr_q),
        .full          (buf_full),
        .drain_last    (drain_last),
        .px_valid      (px_valid),
        .px_ready      (px_ready),
        .px_addr       (px_addr),
        .px_data       (px_data)
    );

endmodule

// File: doc/mand_tile_sequencer.md
Name: mand_tile_sequencer

Overview:
- Sits directly upstream and downstream of the 11-lane Mandelbrot core.
- Walks a rectangular tile of NROWS rows × NBLK blocks of 11 pixels.
- Per block: issues one core request (cx0, cxstep, cy, rq pulse), waits for ack, then unpacks the 77-bit counters word into 11 pixel writes on a valid/ready stream to the framebuffer writer.
- Next block's request overlaps the current block's drain.

Parameters:
- LANES, 11, pixels per core request (fixed by core).
- CW, 7, counter bits per lane.
- AW, 20, framebuffer pixel address width.
- DW, 16, width of nblk/nrows configuration inputs.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches config; ignored while busy
- x0  in  32  fixed-point cx of pixel (0,0)
- y0  in  32  fixed-point cy of row 0
- dx  in  32  cx step per pixel
- dy  in  32  cy step per row
- nblk  in  DW  blocks per row
- nrows  in  DW  rows in tile
- base  in  AW  address of pixel (0,0)
- stride  in  AW  address step per row
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of tile
- core_cx0  out  32  cx of lane 1 of current request
- core_cxstep  out  32  equals latched dx
- core_cy  out  32  cy of current row
- core_rq  out  1  one-cycle request pulse
- core_ack  in  1  one-cycle completion pulse from core
- core_counters  in  LANES*CW  lane k (1..11) at bits [7k-1:7(k-1)]; stable from ack until next rq
- px_valid  out  1  pixel write valid
- px_ready  in  1  pixel write accept
- px_addr  out  AW  pixel address
- px_data  out  CW  iteration count

Behaviour:
- Reset (async, reset=0): FSM to IDLE; busy, done, core_rq, px_valid = 0; core_cx0, core_cxstep, core_cy, px_addr, px_data = 0; internal counters and buffer cleared. Deassertion has no side effects.
- Config latched on start in IDLE; dx11 = 11*dx computed as (dx<<3)+(dx<<1)+dx, mod 2^32.
- Request FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: on start, if nblk==0 or nrows==0, pulse done next cycle and stay IDLE with busy=0. Otherwise go to REQ with busy=1.
  - REQ: core_rq=1 for exactly one cycle; go to WAIT.
  - WAIT: on core_ack, if the drain buffer is empty, capture core_counters plus block base address into the buffer and advance. Otherwise go to HOLD.
  - HOLD: capture once the buffer empties; the core's counters stay stable.
  - Advance: if the last block of the last row was captured, go to IDLE after the drain empties. Otherwise step position and go to REQ.
  - core_ack outside WAIT is ignored.
- Position step, all mod 2^32:
  - Within a row: block+1, core_cx0 += dx11.
  - At row end: block=0, row+1, core_cx0 = x0, core_cy += dy, row_addr += stride.
- Block pixel address = base + row*stride + block*11, kept as accumulators (no multipliers). Address math wraps mod 2^AW.
- Drain side:
  - When the buffer is full, emit lanes 1..11 in order.
  - px_addr = block address + (lane-1); px_data = lane counter.
  - px_valid stays high with addr/data stable until px_ready; one pixel per accepted cycle.
  - Minimum 11 cycles per block at px_ready=1; the buffer frees in the cycle lane 11 is accepted.
- done pulses the cycle after the final pixel is accepted, with busy falling the same cycle. start in that cycle is ignored.
- The first rq fires 2 cycles after start. The next block's rq may fire while the drain is active.
- start while busy is ignored. Reset mid-tile abandons the tile; the core is reset by the same net.

Decomposition:
- Shared package: LANES, CW, the mand FSM state encoding, and a function for 11*x via shifts.
- One sub-module, mand_lane_unpacker:
  - holds the 77-bit buffer and base address;
  - presents load/full and runs the lane counter;
  - drives the px_valid/ready stream.

Test Plan:
- nblk=1, nrows=1, x0=0, dx=4, y0=100, base=0: one rq with cx0=0, cxstep=4, cy=100. Core model acks with lane k count=k. Expect 11 writes, addr 0..10, data 1..11; done pulses once; busy falls.
- nblk=3, nrows=2, dx=1, dy=8, base=1000, stride=64:
  - rq cx0 sequence 0, 11, 22, 0, 11, 22; cy 0, 0, 0, 8, 8, 8.
  - Block addresses 1000, 1011, 1022, 1064, 1075, 1086; 66 writes total.
- Backpressure: px_ready toggles 1010…, and the core acks the second block 3 cycles after rq. Expect HOLD entered, no rq until buffer frees, addr/data stable during stalls, no lost or duplicated pixel.
- nblk=0 or nrows=0: no core_rq; done pulses 1 cycle after start; busy never asserts.
- start pulsed again mid-tile and a spurious core_ack in REQ: both ignored; output sequence identical to the clean run.
- reset asserted during drain of block 2: all outputs 0 immediately (async). After release, a fresh start runs a full tile correctly from block 0.
